// File: rtl/cc_alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU op codes, PSR bit positions.
package cc_alu_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } arb_state_e;

    localparam logic [3:0] OpAndcc = 4'b0000;
    localparam logic [3:0] OpOrcc  = 4'b0001;
    localparam logic [3:0] OpAddcc = 4'b0011;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpAdd   = 4'b1000;
    localparam logic [3:0] OpInc   = 4'b1101;
    localparam logic [3:0] OpIncpc = 4'b1110;

    localparam int unsigned PsrN = 3;
    localparam int unsigned PsrZ = 2;
    localparam int unsigned PsrV = 1;
    localparam int unsigned PsrC = 0;

endpackage

// File: rtl/cc_rr_arbiter2.sv
// Combinational two-way round-robin picker; on contention the requester not served last wins.
module cc_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] winner
);

    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cc_alu_arbiter.sv
// Round-robin sequencer for the shared ALU: IDLE -> EXEC -> DONE, registered result and PSR.
// Define CC_ALUARB_PSR_EN to build the PSR register; otherwise the PSR output is tied to zero.
module cc_alu_arbiter
    import cc_alu_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS           = 32,
    parameter int unsigned DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic                               CC_ALUARB_CLOCK_50,
    input  logic                               CC_ALUARB_RESET_InLow,
    input  logic                               CC_ALUARB_req0_In,
    input  logic                               CC_ALUARB_req1_In,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_op0_InBUS,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_op1_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_dataA0_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_dataB0_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_dataA1_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_dataB1_InBUS,
    output logic                               CC_ALUARB_grant0_Out,
    output logic                               CC_ALUARB_grant1_Out,
    output logic                               CC_ALUARB_done0_Out,
    output logic                               CC_ALUARB_done1_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_result_OutBUS,
    output logic [3:0]                         CC_ALUARB_psr_OutBUS,
    output logic                               CC_ALUARB_busy_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluA_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_aluSel_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUARB_aluData_InBUS,
    input  logic                               CC_ALUARB_aluOverflow_InLow,
    input  logic                               CC_ALUARB_aluCarry_InLow,
    input  logic                               CC_ALUARB_aluNegative_InLow,
    input  logic                               CC_ALUARB_aluZero_InLow,
    input  logic                               CC_ALUARB_aluSetFlags_In
);

    arb_state_e                         state_q, state_d;
    logic                               win_q, win_d;
    logic                               last_q, last_d;
    logic [DATAWIDTH_BUS-1:0]           opa_q, opa_d;
    logic [DATAWIDTH_BUS-1:0]           opb_q, opb_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0] sel_q, sel_d;
    logic [DATAWIDTH_BUS-1:0]           result_q, result_d;
    logic [1:0]                         pick;

    cc_rr_arbiter2 u_rr (
        .req    ({CC_ALUARB_req1_In, CC_ALUARB_req0_In}),
        .last   (last_q),
        .winner (pick)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sel_d    = sel_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (|pick) begin
                    win_d   = pick[1];
                    opa_d   = pick[1] ? CC_ALUARB_dataA1_InBUS : CC_ALUARB_dataA0_InBUS;
                    opb_d   = pick[1] ? CC_ALUARB_dataB1_InBUS : CC_ALUARB_dataB0_InBUS;
                    sel_d   = pick[1] ? CC_ALUARB_op1_InBUS : CC_ALUARB_op0_InBUS;
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d = CC_ALUARB_aluData_InBUS;
                state_d  = StDone;
            end
            StDone: begin
                last_d  = win_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CC_ALUARB_CLOCK_50 or negedge CC_ALUARB_RESET_InLow) begin
        if (!CC_ALUARB_RESET_InLow) begin
            state_q  <= StIdle;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            sel_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sel_q    <= sel_d;
            result_q <= result_d;
        end
    end

    assign CC_ALUARB_grant0_Out    = (state_q == StExec) && !win_q;
    assign CC_ALUARB_grant1_Out    = (state_q == StExec) && win_q;
    assign CC_ALUARB_done0_Out     = (state_q == StDone) && !win_q;
    assign CC_ALUARB_done1_Out     = (state_q == StDone) && win_q;
    assign CC_ALUARB_busy_Out      = (state_q != StIdle);
    assign CC_ALUARB_result_OutBUS = result_q;
    assign CC_ALUARB_aluA_OutBUS   = opa_q;
    assign CC_ALUARB_aluB_OutBUS   = opb_q;
    assign CC_ALUARB_aluSel_OutBUS = sel_q;

`ifdef CC_ALUARB_PSR_EN
    logic [3:0] psr_q;

    // ALU flags arrive active-low; the PSR stores them active-high.
    always_ff @(posedge CC_ALUARB_CLOCK_50 or negedge CC_ALUARB_RESET_InLow) begin
        if (!CC_ALUARB_RESET_InLow) begin
            psr_q <= 4'b0000;
        end else if ((state_q == StExec) && !CC_ALUARB_aluSetFlags_In) begin
            psr_q[PsrN] <= ~CC_ALUARB_aluNegative_InLow;
            psr_q[PsrZ] <= ~CC_ALUARB_aluZero_InLow;
            psr_q[PsrV] <= ~CC_ALUARB_aluOverflow_InLow;
            psr_q[PsrC] <= ~CC_ALUARB_aluCarry_InLow;
        end
    end

    assign CC_ALUARB_psr_OutBUS = psr_q;
`else
    logic unused_flags;
    assign unused_flags = ^{CC_ALUARB_aluOverflow_InLow, CC_ALUARB_aluCarry_InLow,
                            CC_ALUARB_aluNegative_InLow, CC_ALUARB_aluZero_InLow,
                            CC_ALUARB_aluSetFlags_In};
    assign CC_ALUARB_psr_OutBUS = 4'b0000;
`endif

endmodule
